// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer: loads a cipher key, runs 10 rounds that
// borrow a shared S-box over req/ack, and serves the 11 round keys by index.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, key_in       begin expansion of key_in (accepted in IDLE/DONE)
//   busy, done          expansion in progress / one-cycle completion pulse
//   keys_valid          all 11 round keys stored
//   sbox_req, sbox_word S-box request carrying RotWord(w3), held until ack
//   sbox_ack, sbox_data S-box grant with SubWord result in the same cycle
//   rk_idx, rk_data     round-key read port (0 when invalid or idx > 10)
//
// Build option: define KEY_SCHED_RDREG_EN to register rk_data (1-cycle
// latency); otherwise rk_data is combinational from rk_idx.

module aes_key_sched_ctrl #(
   parameter int unsigned NROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         done,
   output logic         keys_valid,
   output logic         sbox_req,
   output logic [31:0]  sbox_word,
   input  logic         sbox_ack,
   input  logic [31:0]  sbox_data,
   input  logic [3:0]   rk_idx,
   output logic [127:0] rk_data
);

   localparam logic [3:0] LAST = 4'(NROUNDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_EXP,
      S_DONE
   } state_t;

   state_t       state_q, state_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [31:0]  t_q, t_d;
   logic         kv_q, kv_d;

   logic [127:0] slot_q [0:10];
   logic         we;
   logic [3:0]   widx;
   logic [127:0] wdata;

   logic [127:0] kprev;
   logic [31:0]  r, w4, w5, w6, w7;
   logic [7:0]   rcon_nx;

   // Previous round key; rnd_q stays in 1..10 so the index is in range.
   assign kprev = slot_q[rnd_q - 4'd1];

   assign r  = t_q ^ {rcon_q, 24'h000000};
   assign w4 = r ^ kprev[127:96];
   assign w5 = w4 ^ kprev[95:64];
   assign w6 = w5 ^ kprev[63:32];
   assign w7 = w6 ^ kprev[31:0];

   assign rcon_nx = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);

   assign busy       = (state_q == S_REQ) || (state_q == S_EXP);
   assign done       = (state_q == S_DONE);
   assign keys_valid = kv_q;
   assign sbox_req   = (state_q == S_REQ);

   // slot[rnd-1] cannot change while in REQ, so the word stays stable.
   assign sbox_word = sbox_req ? {kprev[23:0], kprev[31:24]} : 32'h0;

   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      rcon_d  = rcon_q;
      t_d     = t_q;
      kv_d    = kv_q;
      we      = 1'b0;
      widx    = 4'd0;
      wdata   = key_in;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               we      = 1'b1;
               rnd_d   = 4'd1;
               rcon_d  = 8'h01;
               kv_d    = 1'b0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (sbox_ack) begin
               t_d     = sbox_data;
               state_d = S_EXP;
            end
         end
         S_EXP: begin
            we    = 1'b1;
            widx  = rnd_q;
            wdata = {w4, w5, w6, w7};
            if (rnd_q == LAST) begin
               kv_d    = 1'b1;
               state_d = S_DONE;
            end else begin
               rnd_d   = rnd_q + 4'd1;
               rcon_d  = rcon_nx;
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rnd_q   <= 4'd1;
         rcon_q  <= 8'h01;
         t_q     <= 32'h0;
         kv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         rcon_q  <= rcon_d;
         t_q     <= t_d;
         kv_q    <= kv_d;
      end
   end

   // Key buffer is not reset; reset blocks the write so no partial round lands.
   always_ff @(posedge clk) begin
      if (rst_n && we) begin
         slot_q[widx] <= wdata;
      end
   end

   logic         rd_ok;
   logic [127:0] rd_val;

   assign rd_ok  = kv_q && (rk_idx <= 4'd10);
   assign rd_val = rd_ok ? slot_q[rk_idx] : 128'h0;

`ifdef KEY_SCHED_RDREG_EN
   logic [127:0] rk_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rk_q <= 128'h0;
      end else begin
         rk_q <= rd_val;
      end
   end

   assign rk_data = rk_q;
`else
   assign rk_data = rd_val;
`endif

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Sequencer for the AES-128 key-expansion round datapath. Loads a 128-bit cipher key, then runs 10 expansion rounds.
- Each round requests SubWord(RotWord(w3)) from a shared S-box resource over a req/ack handshake. It then applies the round constant and the w4..w7 XOR chain, and stores the result.
- The 11 round keys are held in a local buffer and read through an indexed port by the cipher round controller.

Parameters:
- NROUNDS, 10, number of expansion rounds (fixed for AES-128; values other than 10 are unsupported).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin expansion of key_in; sampled only in IDLE or DONE.
- key_in  in  128  cipher key; w0 = [127:96], w3 = [31:0].
- busy  out  1  high from accepted start until the final key is written.
- done  out  1  one-cycle pulse after round NROUNDS is stored.
- keys_valid  out  1  high once all 11 keys are stored; cleared by start or reset.
- sbox_req  out  1  S-box request; held until ack.
- sbox_word  out  32  RotWord(w3) = {w3[23:0], w3[31:24]}; stable while sbox_req is high.
- sbox_ack  in  1  S-box grant; sbox_data is valid in the same cycle.
- sbox_data  in  32  SubWord result.
- rk_idx  in  4  round key select, 0..10.
- rk_data  out  128  selected round key.

Behaviour:
- Reset (rst_n=0 at edge):
  - state=IDLE; busy=0, done=0, keys_valid=0, sbox_req=0, sbox_word=0.
  - Round counter = 1; rcon = 8'h01.
  - Buffer contents don't-care; rk_data reads 0 while keys_valid=0.
  - Reset mid-expansion aborts immediately; no partial round is written.
- States:
  - IDLE: start=1 → write key_in to slot 0, rcon=01, rnd=1, busy=1, go to REQ.
  - REQ: sbox_req=1, sbox_word=RotWord(slot[rnd-1][31:0]). If sbox_ack=1, capture sbox_data into t and go to EXP; otherwise stay.
  - EXP: sbox_req=0; compute and write slot[rnd].
    - If rnd=NROUNDS: go to DONE with busy=0 and keys_valid=1.
    - Else: rnd+1, rcon=xtime(rcon), go to REQ.
  - DONE: done=1 for exactly this cycle. start=1 here is accepted as in IDLE (keys_valid cleared). Otherwise go to IDLE.
- Expansion arithmetic:
  - Inputs: previous key k = slot[rnd-1]; r = t with bits [31:24] XOR rcon.
  - w4 = r ^ k[127:96]; w5 = w4 ^ k[95:64]; w6 = w5 ^ k[63:32]; w7 = w6 ^ k[31:0].
  - Stored key = {w4, w5, w6, w7}.
- rcon update: xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00). Sequence: 01,02,04,08,10,20,40,80,1B,36.
- Latency: with sbox_ack high on the first REQ cycle, start → done is 21 cycles (start edge + 10 × (REQ+EXP)). Each ack wait cycle adds 1.
- Handshake rules:
  - sbox_ack outside REQ is ignored.
  - sbox_req never drops without an ack, except on reset.
  - sbox_word must not change while sbox_req=1.
- start handling:
  - start while busy is ignored; key_in may change freely during expansion.
  - start held continuously re-triggers only from IDLE or DONE.
- Read port:
  - rk_data = slot[rk_idx] when keys_valid=1 and rk_idx≤10; otherwise 0.
  - Combinational (see optional feature).
- Storage: 11×128-bit register array.

Optional Feature:
- KEY_SCHED_RDREG_EN defined:
  - rk_data is registered: one cycle of latency from rk_idx.
  - Reset value 0; gating rules unchanged, evaluated on the registered sample.
- Undefined: rk_data is combinational from rk_idx with zero latency.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, ack tied high:
  - rk[1] = a0fafe1788542cb123a339392a6c7605, rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done pulses exactly 21 cycles after start; busy falls on the same edge.
- Key 5468617473206d79204b756e67204675 ("Thats my Kung Fu"):
  - rk[1] = e232fcf191129188b159e4e6d679a293.
  - First sbox_word = 67204675 rotated = 20467567.
- Random 0–5 cycle ack delays with an S-box model:
  - Keys are identical to the zero-wait run.
  - sbox_word is stable while req is high; latency = 21 + total wait cycles.
  - Spurious ack in IDLE/EXP has no effect.
- Trace rcon across rounds 1..10:
  - XOR byte applied equals 01,02,04,08,10,20,40,80,1B,36.
- rst_n=0 during round 5:
  - Next cycle: all outputs at reset values; sbox_req=0; rk_data=0.
  - A new start completes with correct keys.
- Reads and start handling:
  - rk_idx=11..15 → 0. Read before completion → 0.
  - start asserted while busy → ignored.
  - start in the DONE cycle → restarts; keys_valid drops the next cycle.
